// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI register-file configuration master.
package spi_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP
   } state_e;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   localparam logic [ADDR_W-1:0] REG_EN_OUT_LO  = 7'h00;
   localparam logic [ADDR_W-1:0] REG_EN_OUT_HI  = 7'h01;
   localparam logic [ADDR_W-1:0] REG_EN_PWM_LO  = 7'h02;
   localparam logic [ADDR_W-1:0] REG_EN_PWM_HI  = 7'h03;
   localparam logic [ADDR_W-1:0] REG_PWM_DUTY   = 7'h04;

   localparam logic WRITE_BIT = 1'b1;

   function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
      return {WRITE_BIT, addr, data};
   endfunction

endpackage

// File: rtl/spi_cfg_arbiter.sv
// Requester arbiter: one-hot grant from req_valid. Round-robin when
// SPI_CFG_RR_ARB_EN is defined, otherwise fixed priority (lowest index wins).
module spi_cfg_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);

   localparam int unsigned N = NUM_REQ;

   logic found;

`ifdef SPI_CFG_RR_ARB_EN
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   int unsigned      nxt;

   // Nested constant loops keep every select index static after unrolling.
   always_comb begin
      grant = '0;
      found = 1'b0;
      nxt   = 0;
      for (int unsigned p = 0; p < N; p++) begin
         if (32'(rr_ptr_q) == p) begin
            for (int unsigned i = 0; i < N; i++) begin
               if (!found && req_valid[(p + i) % N]) begin
                  found                = 1'b1;
                  grant[(p + i) % N]   = 1'b1;
                  nxt                  = (p + i + 1) % N;
               end
            end
         end
      end
      rr_ptr_d = (advance && found) ? PTR_W'(nxt) : rr_ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`else
   logic unused_ok;
   assign unused_ok = ^{clk, rst, advance};

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req_valid[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/spi_cfg_master.sv
// SPI configuration master: arbitrates requesters and sends 16-bit write frames
// (mode 0, MSB first). Arbitration policy selected by SPI_CFG_RR_ARB_EN.
module spi_cfg_master
   import spi_cfg_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      ncs,
   output logic                      sclk,
   output logic                      copi
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   state_e               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [3:0]           bit_q, bit_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 ncs_q, ncs_d;
   logic                 sclk_q, sclk_d;
   logic                 copi_q, copi_d;
   logic                 done_q, done_d;

   logic [NUM_REQ-1:0]   grant;
   logic                 accept;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_data;

   spi_cfg_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .advance   (accept),
      .grant     (grant)
   );

   assign req_ready = (state_q == IDLE) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign ncs       = ncs_q;
   assign sclk      = sclk_q;
   assign copi      = copi_q;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[ADDR_W*i +: ADDR_W];
            sel_data = req_data[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      gap_d   = gap_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      ncs_d   = ncs_q;
      sclk_d  = sclk_q;
      copi_d  = copi_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SETUP;
               div_d   = '0;
               frame_d = build_frame(sel_addr, sel_data);
               ncs_d   = 1'b0;
               sclk_d  = 1'b0;
               copi_d  = frame_d[FRAME_W-1];
            end
         end
         SETUP: begin
            if (div_q == DIV_LAST) begin
               state_d = SHIFT;
               div_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d = '0;
               if (sclk_q) begin
                  // Rotate so the register's MSB is always the bit on the wire.
                  sclk_d  = 1'b0;
                  frame_d = {frame_q[FRAME_W-2:0], frame_q[FRAME_W-1]};
                  copi_d  = (bit_q == 4'd15) ? 1'b0 : frame_q[FRAME_W-2];
               end else if (bit_q == 4'd15) begin
                  state_d = GAP;
                  bit_d   = '0;
                  gap_d   = '0;
                  ncs_d   = 1'b1;
                  copi_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  bit_d  = bit_q + 4'd1;
                  sclk_d = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         gap_q   <= '0;
         bit_q   <= '0;
         frame_q <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         ncs_q   <= ncs_d;
         sclk_q  <= sclk_d;
         copi_q  <= copi_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: two instances (CLK_DIV 4 and 2), each with a
// frame-capturing register-file model and an expected-frame scoreboard.
module tb_spi_cfg_master;

  localparam int CS_GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid [2];
  logic [13:0] req_addr [2];
  logic [15:0] req_data [2];
  logic [1:0]  req_ready [2];
  logic        busy [2];
  logic        done [2];
  logic        ncs  [2];
  logic        sclk [2];
  logic        copi [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD = (g == 0) ? 4 : 2;

    spi_cfg_master #(.NUM_REQ(2), .CLK_DIV(CD), .CS_GAP(CS_GAP)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_addr  (req_addr[g]),
      .req_data  (req_data[g]),
      .req_ready (req_ready[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .ncs       (ncs[g]),
      .sclk      (sclk[g]),
      .copi      (copi[g])
    );

    logic [15:0] exp_q [$];
    logic [7:0]  regs [128];
    logic [15:0] sh, expv;
    logic        pncs, psclk, pcopi, rose;
    int          nbits, lowcnt, hicnt, run, done_cnt;

    initial begin
      for (int unsigned i = 0; i < 128; i++) regs[i] = 8'h00;
      pncs = 1'b1; psclk = 1'b0; pcopi = 1'b0;
      nbits = 0; lowcnt = 0; hicnt = 1000; run = 0; done_cnt = 0; sh = '0;
    end

    always @(negedge clk) begin
      if (rst) begin
        pncs = 1'b1; psclk = 1'b0; pcopi = 1'b0;
        nbits = 0; lowcnt = 0; hicnt = 1000; run = 0;
      end else begin
        rose = !pncs && ncs[g];
        checks++;
        if (done[g] !== rose) begin
          errors++;
          $error("FAIL done_pulse observed=%0h expected=%0h", done[g], rose);
        end
        checks++;
        if ((req_ready[g] & {2{busy[g]}}) !== 2'b00) begin
          errors++;
          $error("FAIL ready_while_busy observed=%0h expected=0", req_ready[g] & {2{busy[g]}});
        end
        if (done[g]) done_cnt++;
        if (pncs && !ncs[g]) begin
          checks++;
          if (hicnt < CS_GAP) begin
            errors++;
            $error("FAIL cs_gap_min observed=%0d expected>=%0d", hicnt, CS_GAP);
          end
          nbits = 0; lowcnt = 0; run = 0; sh = '0;
        end
        if (!ncs[g]) begin
          lowcnt++;
          if (sclk[g] !== psclk && lowcnt > 1) begin
            checks++;
            if (run !== CD) begin
              errors++;
              $error("FAIL sclk_half_period observed=%0d expected=%0d", run, CD);
            end
            run = 1;
            if (sclk[g]) begin
              checks++;
              if (copi[g] !== pcopi) begin
                errors++;
                $error("FAIL copi_stable_at_rise observed=%0h expected=%0h", copi[g], pcopi);
              end
              sh = {sh[14:0], copi[g]};
              nbits++;
            end
          end else begin
            run++;
          end
        end else begin
          hicnt++;
        end
        if (rose) begin
          checks++;
          if (lowcnt !== 33 * CD) begin
            errors++;
            $error("FAIL ncs_low_cycles observed=%0d expected=%0d", lowcnt, 33 * CD);
          end
          checks++;
          if (nbits !== 16) begin
            errors++;
            $error("FAIL frame_bits observed=%0d expected=16", nbits);
          end
          checks++;
          if (run !== CD) begin
            errors++;
            $error("FAIL last_low_phase observed=%0d expected=%0d", run, CD);
          end
          checks++;
          if ({sclk[g], copi[g]} !== 2'b00) begin
            errors++;
            $error("FAIL idle_sclk_copi observed=%0h expected=0", {sclk[g], copi[g]});
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL unexpected_frame observed=%0h expected=none", sh);
          end else begin
            expv = exp_q.pop_front();
            if (sh !== expv) begin
              errors++;
              $error("FAIL frame_word observed=%0h expected=%0h", sh, expv);
            end
          end
          if (sh[15]) regs[sh[14:8]] = sh[7:0];
          hicnt = 1;
        end
        pncs = ncs[g]; psclk = sclk[g]; pcopi = copi[g];
      end
    end
  end

  function automatic void push_exp(input int g, input logic [15:0] v);
    if (g == 0) g_dut[0].exp_q.push_back(v);
    else        g_dut[1].exp_q.push_back(v);
  endfunction

  function automatic int qsize(input int g);
    return (g == 0) ? g_dut[0].exp_q.size() : g_dut[1].exp_q.size();
  endfunction

  task automatic set_req(input int g, input int r, input logic v,
                         input logic [6:0] a, input logic [7:0] d);
    req_valid[g][r]       = v;
    req_addr[g][7*r +: 7] = a;
    req_data[g][8*r +: 8] = d;
  endtask

  task automatic wait_grant(input int g, input int r);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (req_ready[g][r] && req_valid[g][r]) break;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $error("FAIL grant_timeout observed=%0d expected<3000", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      #1;
      if (qsize(g) == 0 && !busy[g]) break;
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $error("FAIL idle_timeout observed=%0d expected<5000", n);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  int dcnt, lim0, lim1, cnt0, cnt1, n;
  logic gr0, gr1;

  initial begin
    for (int unsigned g = 0; g < 2; g++) begin
      req_valid[g] = '0; req_addr[g] = '0; req_data[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int unsigned g = 0; g < 2; g++) begin
      checks++;
      if ({ncs[g], sclk[g], copi[g], busy[g], done[g], req_ready[g]} !== 7'b1000000) begin
        errors++;
        $error("FAIL reset_outputs observed=%0h expected=40",
               {ncs[g], sclk[g], copi[g], busy[g], done[g], req_ready[g]});
      end
    end
    #2 rst = 1'b0;

    dcnt = g_dut[0].done_cnt;
    push_exp(0, 16'h8480);
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 7'h04, 8'h80);
    wait_grant(0, 0);
    set_req(0, 0, 1'b0, 7'h00, 8'h00);
    wait_idle(0);
    checks++;
    if (g_dut[0].regs[4] !== 8'h80) begin
      errors++;
      $error("FAIL t1_duty_reg observed=%0h expected=80", g_dut[0].regs[4]);
    end
    checks++;
    if ((g_dut[0].done_cnt - dcnt) !== 1) begin
      errors++;
      $error("FAIL t1_done_count observed=%0d expected=1", g_dut[0].done_cnt - dcnt);
    end

    pulse_reset();
    push_exp(0, 16'h80FF);
    push_exp(0, 16'h820F);
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 7'h00, 8'hFF);
    set_req(0, 1, 1'b1, 7'h02, 8'h0F);
    wait_grant(0, 0);
    set_req(0, 0, 1'b0, 7'h00, 8'h00);
    wait_grant(0, 1);
    set_req(0, 1, 1'b0, 7'h00, 8'h00);
    wait_idle(0);
    checks++;
    if (g_dut[0].regs[0] !== 8'hFF) begin
      errors++;
      $error("FAIL t2_reg0 observed=%0h expected=ff", g_dut[0].regs[0]);
    end
    checks++;
    if (g_dut[0].regs[2] !== 8'h0F) begin
      errors++;
      $error("FAIL t2_reg2 observed=%0h expected=0f", g_dut[0].regs[2]);
    end

    pulse_reset();
`ifdef SPI_CFG_RR_ARB_EN
    lim0 = 2; lim1 = 2;
    push_exp(0, 16'h8210); push_exp(0, 16'h8320);
    push_exp(0, 16'h8211); push_exp(0, 16'h8321);
`else
    lim0 = 4; lim1 = 1;
    push_exp(0, 16'h8210); push_exp(0, 16'h8211);
    push_exp(0, 16'h8212); push_exp(0, 16'h8213);
    push_exp(0, 16'h8320);
`endif
    cnt0 = 0; cnt1 = 0; n = 0;
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 7'h02, 8'h10);
    set_req(0, 1, 1'b1, 7'h03, 8'h20);
    while ((cnt0 < lim0 || cnt1 < lim1) && n < 20000) begin
      @(negedge clk);
      n++;
      gr0 = req_ready[0][0] && req_valid[0][0];
      gr1 = req_ready[0][1] && req_valid[0][1];
      if (gr0 || gr1) begin
        @(posedge clk); #1;
        if (gr0) begin
          cnt0++;
          set_req(0, 0, (cnt0 < lim0), 7'h02, 8'(8'h10 + cnt0));
        end
        if (gr1) begin
          cnt1++;
          set_req(0, 1, (cnt1 < lim1), 7'h03, 8'(8'h20 + cnt1));
        end
      end
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $error("FAIL t3_timeout observed=%0d expected<20000", n);
    end
    wait_idle(0);

    pulse_reset();
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 7'h01, 8'h33);
    wait_grant(0, 0);
    set_req(0, 0, 1'b0, 7'h00, 8'h00);
    n = 0;
    while (n < 2000) begin
      @(negedge clk); #1;
      if (g_dut[0].nbits == 8) break;
      n++;
    end
    checks++;
    if (g_dut[0].nbits !== 8) begin
      errors++;
      $error("FAIL t4_reach_bit7 observed=%0d expected=8", g_dut[0].nbits);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ncs[0], sclk[0], copi[0], busy[0]} !== 4'b1000) begin
      errors++;
      $error("FAIL t4_abort_pins observed=%0h expected=8", {ncs[0], sclk[0], copi[0], busy[0]});
    end
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (g_dut[0].regs[1] !== 8'h00) begin
      errors++;
      $error("FAIL t4_reg_unchanged observed=%0h expected=00", g_dut[0].regs[1]);
    end
    push_exp(0, 16'h8133);
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 7'h01, 8'h33);
    wait_grant(0, 0);
    set_req(0, 0, 1'b0, 7'h00, 8'h00);
    wait_idle(0);
    checks++;
    if (g_dut[0].regs[1] !== 8'h33) begin
      errors++;
      $error("FAIL t4_full_frame_reg observed=%0h expected=33", g_dut[0].regs[1]);
    end

    push_exp(1, 16'h81A5);
    push_exp(1, 16'h835A);
    @(posedge clk); #1;
    set_req(1, 0, 1'b1, 7'h01, 8'hA5);
    wait_grant(1, 0);
    set_req(1, 0, 1'b1, 7'h03, 8'h5A);
    wait_grant(1, 0);
    set_req(1, 0, 1'b0, 7'h00, 8'h00);
    wait_idle(1);
    checks++;
    if (g_dut[1].regs[1] !== 8'hA5) begin
      errors++;
      $error("FAIL t5_reg1 observed=%0h expected=a5", g_dut[1].regs[1]);
    end
    checks++;
    if (g_dut[1].regs[3] !== 8'h5A) begin
      errors++;
      $error("FAIL t5_reg3 observed=%0h expected=5a", g_dut[1].regs[3]);
    end

    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if ({ncs[0], sclk[0], busy[0], req_ready[0]} !== 5'b10000) begin
        errors++;
        $error("FAIL t6_idle_pins observed=%0h expected=10", {ncs[0], sclk[0], busy[0], req_ready[0]});
      end
    end

    checks++;
    if ((qsize(0) + qsize(1)) !== 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=0", qsize(0) + qsize(1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
